// File: rtl/ti_share_masker_pkg.sv
// rtl/ti_share_masker_pkg.sv - shared types and the unrolled Galois LFSR advance for the TI masker
package ti_mask_pkg;

    localparam int NIBBLE_W       = 4;
    localparam int LFSR_MAX_W     = 32;
    localparam int LFSR_MAX_STEPS = 32;

    typedef logic [NIBBLE_W-1:0] nibble_t;

    typedef enum logic [0:0] {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } fsm_e;

    // Fixed loop bound keeps the unroll static; steps beyond n pass the state through.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_step_n(
        input logic [LFSR_MAX_W-1:0] state,
        input logic [LFSR_MAX_W-1:0] taps,
        input int                    n
    );
        logic [LFSR_MAX_W-1:0] s;
        s = state;
        for (int i = 0; i < LFSR_MAX_STEPS; i++) begin
            if (i < n) begin
                s = s[0] ? ((s >> 1) ^ taps) : (s >> 1);
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/ti_share_masker_if.sv
// rtl/ti_share_masker_if.sv - nibble-in / shares-out valid-ready bundle for the TI masker
interface ti_share_masker_if
    import ti_mask_pkg::*;
#(
    parameter int NUM_SHARES = 2
);
    logic                           in_valid;
    logic                           in_ready;
    nibble_t                        in_data;
    logic                           out_valid;
    logic                           out_ready;
    logic [NIBBLE_W*NUM_SHARES-1:0] out_shares;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_shares
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_shares
    );
endinterface

// File: rtl/ti_share_masker_lfsr.sv
// rtl/ti_share_masker_lfsr.sv - Galois LFSR advancing a fixed number of steps per enable, with zero guard and load
module ti_lfsr_gen
    import ti_mask_pkg::*;
#(
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1,
    parameter int                STEPS     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              advance_i,
    input  logic              load_i,
    input  logic [LFSR_W-1:0] load_data_i,
    output logic [LFSR_W-1:0] state_o
);
    logic [LFSR_W-1:0]     state_q;
    logic [LFSR_W-1:0]     state_d;
    logic [LFSR_W-1:0]     next_state;
    logic [LFSR_MAX_W-1:0] stepped;
    logic                  unused_stepped;

    assign stepped        = lfsr_step_n(32'(state_q), 32'(LFSR_TAPS), STEPS);
    assign unused_stepped = ^stepped;

    // An all-zero state would lock the register, so it is replaced by the seed.
    always_comb begin
        next_state = state_q;
        if (load_i) begin
            next_state = load_data_i;
        end else if (advance_i) begin
            next_state = stepped[LFSR_W-1:0];
        end
        state_d = (next_state == '0) ? LFSR_SEED : next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LFSR_SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/ti_share_masker.sv
// rtl/ti_share_masker.sv - splits a nibble into NUM_SHARES Boolean shares; TI_MASKER_SEED_LOAD_EN adds a seed load port
module ti_share_masker
    import ti_mask_pkg::*;
#(
    parameter int                NUM_SHARES = 2,
    parameter int                LFSR_W     = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS  = 16'hB400,
    parameter logic [LFSR_W-1:0] LFSR_SEED  = 16'hACE1,
    parameter int                WARMUP_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef TI_MASKER_SEED_LOAD_EN
    input  logic              seed_valid,
    input  logic [LFSR_W-1:0] seed_data,
`endif
    ti_share_masker_if.slave  bus_if
);
    localparam int             K         = NIBBLE_W * (NUM_SHARES - 1);
    localparam int             SH_W      = NIBBLE_W * NUM_SHARES;
    localparam logic [0:0]     ST_WARMUP = 1'(WARMUP);
    localparam logic [0:0]     ST_RUN    = 1'(RUN);
    localparam logic [15:0]    WARM_LAST = 16'(WARMUP_CYC - 1);

    logic [0:0]        fsm_q, fsm_d;
    logic [15:0]       warm_cnt_q, warm_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [SH_W-1:0]   shares_q, shares_d;
    logic [SH_W-1:0]   fresh_shares;
    logic [LFSR_W-1:0] lfsr_state;
    logic              unused_lfsr;
    logic              seed_load;
    logic [LFSR_W-1:0] seed_word;
    logic              in_ready;
    logic              accept;
    logic              pop;

`ifdef TI_MASKER_SEED_LOAD_EN
    assign seed_load = seed_valid;
    assign seed_word = seed_data;
`else
    assign seed_load = 1'b0;
    assign seed_word = '0;
`endif

    assign in_ready = (fsm_q == ST_RUN) && !seed_load && (!out_valid_q || bus_if.out_ready);
    assign accept   = bus_if.in_valid && in_ready;
    assign pop      = out_valid_q && bus_if.out_ready;

    // Randomness is consumed only by warmup and accepts; idle RUN cycles hold the LFSR.
    ti_lfsr_gen #(
        .LFSR_W    (LFSR_W),
        .LFSR_TAPS (LFSR_TAPS),
        .LFSR_SEED (LFSR_SEED),
        .STEPS     (K)
    ) u_lfsr (
        .clk         (clk),
        .rst_n       (rst_n),
        .advance_i   ((fsm_q == ST_WARMUP) || accept),
        .load_i      (seed_load),
        .load_data_i (seed_word),
        .state_o     (lfsr_state)
    );

    assign unused_lfsr = ^lfsr_state;

    always_comb begin
        fsm_d      = fsm_q;
        warm_cnt_d = warm_cnt_q;
        if (seed_load) begin
            fsm_d      = ST_WARMUP;
            warm_cnt_d = '0;
        end else if (fsm_q == ST_WARMUP) begin
            warm_cnt_d = warm_cnt_q + 16'd1;
            if (warm_cnt_q == WARM_LAST) begin
                fsm_d = ST_RUN;
            end
        end
    end

    // Last share absorbs the nibble so all shares recombine to in_data.
    always_comb begin
        nibble_t acc;
        acc          = bus_if.in_data;
        fresh_shares = '0;
        for (int i = 0; i < NUM_SHARES - 1; i++) begin
            fresh_shares[i*NIBBLE_W +: NIBBLE_W] = lfsr_state[i*NIBBLE_W +: NIBBLE_W];
            acc = acc ^ lfsr_state[i*NIBBLE_W +: NIBBLE_W];
        end
        fresh_shares[SH_W-1 -: NIBBLE_W] = acc;
    end

    always_comb begin
        shares_d    = shares_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            shares_d    = fresh_shares;
            out_valid_d = 1'b1;
        end else if (pop) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= ST_WARMUP;
            warm_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            shares_q    <= '0;
        end else begin
            fsm_q       <= fsm_d;
            warm_cnt_q  <= warm_cnt_d;
            out_valid_q <= out_valid_d;
            shares_q    <= shares_d;
        end
    end

    assign bus_if.in_ready   = in_ready;
    assign bus_if.out_valid  = out_valid_q;
    assign bus_if.out_shares = shares_q;

endmodule

// File: tb/tb_ti_share_masker.sv
// tb/tb_ti_share_masker.sv - scoreboard bench for ti_share_masker (2-share main DUT, 3/4-share recombination DUTs)
module tb_ti_share_masker;
    import ti_mask_pkg::*;

    typedef struct {
        logic [7:0] shares;
        logic [3:0] nib;
    } exp_t;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        rst_ns_n = 1'b0;
    int          checks  = 0;
    int          failures = 0;
    int          ns_done = 0;
    exp_t        sb_q[$];
    logic [15:0] m_lfsr;

    always #5 clk = ~clk;

    ti_share_masker_if #(.NUM_SHARES(2)) bus2 ();

`ifdef TI_MASKER_SEED_LOAD_EN
    logic        seed_valid = 1'b0;
    logic [15:0] seed_data  = 16'h0;
`endif

    ti_share_masker #(.NUM_SHARES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef TI_MASKER_SEED_LOAD_EN
        .seed_valid (seed_valid),
        .seed_data  (seed_data),
`endif
        .bus_if     (bus2)
    );

    function automatic logic [15:0] mstep(input logic [15:0] s, input int n);
        logic [15:0] r;
        r = s;
        for (int i = 0; i < n; i++) r = r[0] ? ((r >> 1) ^ 16'hB400) : (r >> 1);
        return r;
    endfunction

    function automatic logic [3:0] xor16(input logic [15:0] v);
        return v[3:0] ^ v[7:4] ^ v[11:8] ^ v[15:12];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic send(input logic [3:0] d, output int waits);
        exp_t e;
        bus2.in_valid = 1'b1;
        bus2.in_data  = d;
        waits = 0;
        @(negedge clk);
        while (!bus2.in_ready && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (!bus2.in_ready) begin
            check("send_timeout", 32'd1, 32'd0);
        end else begin
            e.nib    = d;
            e.shares = {d ^ m_lfsr[3:0], m_lfsr[3:0]};
            sb_q.push_back(e);
            m_lfsr = mstep(m_lfsr, 4);
        end
        @(posedge clk);
        #1;
        bus2.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("drain", sb_q.size(), 0);
        if (n != 0) #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && bus2.out_valid && bus2.out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_output", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("shares", bus2.out_shares, e.shares);
                check("recombine", bus2.out_shares[3:0] ^ bus2.out_shares[7:4], e.nib);
            end
        end
    end

    // Wider share counts: only recombination is checked, over random nibbles.
    for (genvar g = 3; g <= 4; g++) begin : g_ns
        ti_share_masker_if #(.NUM_SHARES(g)) b ();

        ti_share_masker #(.NUM_SHARES(g)) u_dut (
            .clk        (clk),
            .rst_n      (rst_ns_n),
`ifdef TI_MASKER_SEED_LOAD_EN
            .seed_valid (1'b0),
            .seed_data  (16'h0),
`endif
            .bus_if     (b)
        );

        initial begin : drv
            logic [3:0] q[$];
            logic [3:0] d;
            logic [3:0] want;
            int pushed;
            int cyc;
            pushed = 0;
            cyc    = 0;
            d      = 4'($urandom_range(0, 15));
            b.out_ready = 1'b1;
            b.in_valid  = 1'b0;
            b.in_data   = d;
            @(posedge clk);
            #1;
            rst_ns_n   = 1'b1;
            b.in_valid = 1'b1;
            while ((pushed < 1000 || q.size() != 0) && cyc < 5000) begin
                @(negedge clk);
                cyc++;
                if (b.out_valid) begin
                    if (q.size() == 0) begin
                        check("ns_unexpected", 32'd1, 32'd0);
                    end else begin
                        want = q.pop_front();
                        check("ns_xor", xor16(16'(b.out_shares)), want);
                    end
                end
                if (b.in_ready && b.in_valid) begin
                    q.push_back(d);
                    pushed++;
                end
                @(posedge clk);
                #1;
                if (pushed >= 1000) b.in_valid = 1'b0;
                d = 4'($urandom_range(0, 15));
                b.in_data = d;
            end
            check("ns_count", pushed, 1000);
            ns_done++;
        end
    end

    initial begin : main
        int n;
        bus2.in_valid  = 1'b0;
        bus2.in_data   = 4'h0;
        bus2.out_ready = 1'b1;
        #1;
        check("rst_out_valid", bus2.out_valid, 0);
        check("rst_out_shares", bus2.out_shares, 0);
        check("rst_in_ready", bus2.in_ready, 0);

        m_lfsr = mstep(16'hACE1, 16 * 4);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(4'hA, n);
        check("warmup_cycles", n, 16);

        for (int i = 0; i < 16; i++) begin
            send(4'(i), n);
            check("stream_no_stall", n, 0);
        end
        drain();
        check("lfsr_state", dut.u_lfsr.state_o, m_lfsr);

        bus2.out_ready = 1'b0;
        send(4'h5, n);
        bus2.in_valid = 1'b1;
        bus2.in_data  = 4'h6;
        repeat (5) begin
            @(negedge clk);
            check("stall_valid", bus2.out_valid, 1);
            check("stall_shares", bus2.out_shares, sb_q[0].shares);
            check("stall_in_ready", bus2.in_ready, 0);
        end
        @(posedge clk);
        #1;
        bus2.out_ready = 1'b1;
        send(4'h6, n);
        check("reload_same_cycle", n, 0);
        drain();

        bus2.out_ready = 1'b0;
        send(4'h9, n);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", bus2.out_valid, 0);
        check("async_rst_out_shares", bus2.out_shares, 0);
        check("async_rst_in_ready", bus2.in_ready, 0);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus2.out_ready = 1'b1;
        m_lfsr = mstep(16'hACE1, 16 * 4);
        send(4'h3, n);
        check("rewarmup_cycles", n, 16);
        drain();

`ifdef TI_MASKER_SEED_LOAD_EN
        bus2.out_ready = 1'b0;
        send(4'h7, n);
        seed_valid    = 1'b1;
        seed_data     = 16'h0000;
        bus2.in_valid = 1'b1;
        bus2.in_data  = 4'h8;
        @(negedge clk);
        check("seed_in_ready", bus2.in_ready, 0);
        check("seed_pending_valid", bus2.out_valid, 1);
        @(posedge clk);
        #1;
        seed_valid    = 1'b0;
        bus2.in_valid = 1'b0;
        check("seed_zero_guard", dut.u_lfsr.state_o, 16'hACE1);
        m_lfsr = mstep(16'hACE1, 16 * 4);
        bus2.out_ready = 1'b1;
        send(4'h8, n);
        check("seed_warmup_cycles", n, 16);
        drain();
`endif

        n = 0;
        while (ns_done < 2 && n < 10000) begin
            @(posedge clk);
            n++;
        end
        check("ns_done", ns_done, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
